// File: rtl/ka_mac_accumulator.sv
// rtl/ka_mac_accumulator.sv - multiply-accumulate sink for the Karatsuba multiplier product stream
// Sums a programmed number of products modulo 2^ACC_W and presents the total on a valid/ready result port.
module ka_mac_accumulator #(
  parameter int PROD_W = 127,
  parameter int ACC_W  = 136,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              overflow,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic             beat;
  logic [ACC_W:0]   sum;

  // One extra bit on the adder captures the carry out of the accumulator
  assign sum  = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
  assign beat = prod_valid & prod_ready;

  assign acc_out  = acc;
  assign overflow = ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    prod_ready = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        prod_ready = 1'b1;
        if (prod_valid && (count == CNT_W'(1))) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        busy       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      ovf   <= 1'b0;
      count <= '0;
    end else if ((state == IDLE) && start) begin
      acc   <= '0;
      ovf   <= 1'b0;
      count <= len;
    end else if (beat) begin
      acc   <= sum[ACC_W-1:0];
      ovf   <= ovf | sum[ACC_W];
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ka_mac_accumulator.sv
// tb/tb_ka_mac_accumulator.sv - scoreboard bench for ka_mac_accumulator at ACC_W=136 and ACC_W=128
// Both instances share stimulus; each has its own expected-result queue drained by a monitor.
module tb_ka_mac_accumulator;

  localparam logic [126:0] P126 = 127'h1 << 126;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [7:0]   len;
  logic [126:0] prod;
  logic         prod_valid;
  logic         out_ready;

  logic         prod_ready1, overflow1, out_valid1, busy1;
  logic [135:0] acc1;
  logic         prod_ready2, overflow2, out_valid2, busy2;
  logic [127:0] acc2;

  int tests_run = 0;
  int fails     = 0;

  logic [136:0] q1[$];
  logic [128:0] q2[$];
  logic [126:0] stim_q[$];

  always #5 clk = ~clk;

  ka_mac_accumulator #(.PROD_W(127), .ACC_W(136), .CNT_W(8)) dut136 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .prod(prod),
    .prod_valid(prod_valid), .prod_ready(prod_ready1), .acc_out(acc1),
    .overflow(overflow1), .out_valid(out_valid1), .out_ready(out_ready), .busy(busy1)
  );

  ka_mac_accumulator #(.PROD_W(127), .ACC_W(128), .CNT_W(8)) dut128 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .prod(prod),
    .prod_valid(prod_valid), .prod_ready(prod_ready2), .acc_out(acc2),
    .overflow(overflow2), .out_valid(out_valid2), .out_ready(out_ready), .busy(busy2)
  );

  task automatic chk(input string name, input logic [136:0] act, input logic [136:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 137'(act), 137'(exp));
  endtask

  task automatic expect_result(input logic [136:0] e1, input logic [128:0] e2);
    q1.push_back(e1);
    q2.push_back(e2);
  endtask

  // Result monitor: compares on every accepted result, independent of stimulus
  always @(negedge clk) begin
    if (rst_n && out_valid1 && out_ready) begin
      if (q1.size() == 0) begin
        tests_run++;
        fails++;
        $display("FAIL dut136 unexpected result: got %0h, expected none", acc1);
      end else begin
        chk("dut136 result {ovf,acc}", {overflow1, acc1}, q1.pop_front());
      end
    end
    if (rst_n && out_valid2 && out_ready) begin
      if (q2.size() == 0) begin
        tests_run++;
        fails++;
        $display("FAIL dut128 unexpected result: got %0h, expected none", acc2);
      end else begin
        chk("dut128 result {ovf,acc}", {8'b0, overflow2, acc2}, {8'b0, q2.pop_front()});
      end
    end
  end

  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog: still running after 5000 cycles, expected finish");
    $fatal(1);
  end

  // All tasks enter and leave 1 time unit after a rising edge
  task automatic start_blk(input logic [7:0] n);
    start = 1'b1;
    len   = n;
    @(posedge clk); #1;
    start = 1'b0;
    len   = '0;
  endtask

  task automatic feed(input bit gap);
    int n;
    n = stim_q.size();
    for (int i = 0; i < n; i++) begin
      if (gap && i > 0) begin
        prod_valid = 1'b0;
        prod       = '0;
        @(negedge clk);
        chk1("gap prod_ready", prod_ready1, 1'b1);
        @(posedge clk); #1;
      end
      prod_valid = 1'b1;
      prod       = stim_q[i];
      @(negedge clk);
      chk1("accum prod_ready", prod_ready1, 1'b1);
      chk1("accum out_valid", out_valid1, 1'b0);
      @(posedge clk); #1;
    end
    prod_valid = 1'b0;
    prod       = '0;
    stim_q.delete();
  endtask

  task automatic finish_blk();
    @(negedge clk);
    chk1("done out_valid", out_valid1, 1'b1);
    chk1("done prod_ready", prod_ready1, 1'b0);
    chk1("done busy", busy1, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("idle out_valid", out_valid1, 1'b0);
    chk1("idle busy", busy1, 1'b0);
    chk1("idle prod_ready", prod_ready1, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    len        = '0;
    prod       = '0;
    prod_valid = 1'b0;
    out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset acc_out", 137'(acc1), 137'd0);
    chk1("reset overflow", overflow1, 1'b0);
    chk1("reset out_valid", out_valid1, 1'b0);
    chk1("reset prod_ready", prod_ready1, 1'b0);
    chk1("reset busy", busy1, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 5 + 7 + 11 back to back
    expect_result(137'd23, 129'd23);
    start_blk(8'd3);
    stim_q = '{127'd5, 127'd7, 127'd11};
    feed(1'b0);
    finish_blk();

    // four 2^126 beats with alternating valid; wraps to zero with carry at 128 bits
    expect_result(137'h1 << 128, 129'h1 << 128);
    start_blk(8'd4);
    stim_q = '{P126, P126, P126, P126};
    feed(1'b1);
    finish_blk();

    expect_result(137'h3 << 126, 129'h3 << 126);
    start_blk(8'd3);
    stim_q = '{P126, P126, P126};
    feed(1'b0);
    finish_blk();

    // five 2^126 beats, then result held under backpressure while starts are ignored
    expect_result(137'h5 << 126, (129'h1 << 128) | (129'h1 << 126));
    out_ready = 1'b0;
    start_blk(8'd5);
    stim_q = '{P126, P126, P126, P126, P126};
    feed(1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk1("bp out_valid", out_valid1, 1'b1);
      chk("bp acc136 stable", 137'(acc1), 137'h5 << 126);
      chk("bp acc128 stable", 137'(acc2), 137'(P126));
      chk1("bp overflow128", overflow2, 1'b1);
      @(posedge clk); #1;
      start = 1'b1;
      len   = 8'd7;
    end
    start     = 1'b0;
    len       = '0;
    out_ready = 1'b1;
    finish_blk();

    expect_result(137'd9, 129'd9);
    start_blk(8'd1);
    stim_q = '{127'd9};
    feed(1'b0);
    finish_blk();

    // len=0 goes straight to DONE and must not consume the waiting product
    expect_result(137'd0, 129'd0);
    prod_valid = 1'b1;
    prod       = 127'd123;
    start_blk(8'd0);
    finish_blk();
    prod_valid = 1'b0;
    prod       = '0;

    // reset after three of eight beats
    start_blk(8'd8);
    stim_q = '{127'd1, 127'd2, 127'd3};
    feed(1'b0);
    @(negedge clk);
    chk1("mid-block busy", busy1, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid reset acc_out", 137'(acc1), 137'd0);
    chk1("mid reset busy", busy1, 1'b0);
    chk1("mid reset prod_ready", prod_ready1, 1'b0);
    chk1("mid reset out_valid", out_valid1, 1'b0);
    chk1("mid reset overflow", overflow1, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    expect_result(137'd2, 129'd2);
    start_blk(8'd2);
    stim_q = '{127'd1, 127'd1};
    feed(1'b0);
    finish_blk();

    repeat (2) @(posedge clk);
    chk("dut136 queue drained", 137'(q1.size()), 137'd0);
    chk("dut128 queue drained", 137'(q2.size()), 137'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
